regfile_sp_bank: RTL and testbench

Parametrised decode-stage storage block for the MIPS pipeline: multi-entry register file, bounded stack pointer and stage-2 output register in one unit. It provides write-through bypass, external forwarding override, pipeline-enable (stall) holding, and sticky stack overflow/underflow detection. It sits between stage-1 instruction fetch and stage-3 execute, and is fed by writeback.

---
 rtl/regfile_pkg.sv | 22 ++
 rtl/regfile_sp_bank_if.sv | 35 +++
 rtl/regfile_sp_bank_stack_ptr_unit.sv | 76 +++++++
 rtl/regfile_sp_bank.sv | 77 +++++++
 tb/tb_regfile_sp_bank.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared encodings and default widths for the decode-stage register/stack block.
package regfile_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 5;
  localparam int unsigned DEF_SP_W   = 8;

  typedef enum logic [1:0] {
    SP_HOLD = 2'b00,
    SP_PUSH = 2'b01,
    SP_POP  = 2'b10,
    SP_LOAD = 2'b11
  } sp_op_e;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_D1   = 2'b01,
    FWD_D2   = 2'b10,
    FWD_BOTH = 2'b11
  } fwd_sel_e;

endpackage

// File: rtl/regfile_sp_bank_if.sv
// Bus bundle for regfile_sp_bank: read/write/stack/forward controls and registered results.
interface regfile_sp_bank_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned SP_W   = 8
);
  logic              en_pipeline;
  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [1:0]        sp_op;
  logic [SP_W-1:0]   sp_load_data;
  logic [1:0]        fwd_sel;
  logic [DATA_W-1:0] fwd_data;
  logic [DATA_W-1:0] data1_out;
  logic [DATA_W-1:0] data2_out;
  logic [SP_W-1:0]   sp_out;
  logic [SP_W-1:0]   sp_addr_out;
  logic              stack_overflow;
  logic              stack_underflow;

  modport master (
    output en_pipeline, rd_addr1, rd_addr2, wr_en, wr_addr, wr_data,
           sp_op, sp_load_data, fwd_sel, fwd_data,
    input  data1_out, data2_out, sp_out, sp_addr_out, stack_overflow, stack_underflow
  );

  modport slave (
    input  en_pipeline, rd_addr1, rd_addr2, wr_en, wr_addr, wr_data,
           sp_op, sp_load_data, fwd_sel, fwd_data,
    output data1_out, data2_out, sp_out, sp_addr_out, stack_overflow, stack_underflow
  );
endinterface

// File: rtl/regfile_sp_bank_stack_ptr_unit.sv
// Bounded downward-growing stack pointer with registered memory address and sticky
// overflow/underflow flags; advances only when the pipeline is enabled.
module stack_ptr_unit
  import regfile_pkg::*;
#(
  parameter int unsigned    SP_W     = 8,
  parameter logic [SP_W-1:0] SP_TOP   = 8'hFF,
  parameter logic [SP_W-1:0] SP_LIMIT = 8'h00
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en_i,
  input  logic [1:0]      op_i,
  input  logic [SP_W-1:0] load_i,
  output logic [SP_W-1:0] sp_o,
  output logic [SP_W-1:0] addr_o,
  output logic            ovf_o,
  output logic            unf_o
);

  logic [SP_W-1:0] sp_q, sp_d;
  logic [SP_W-1:0] addr_q, addr_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;

  always_comb begin
    sp_d   = sp_q;
    addr_d = addr_q;
    ovf_d  = ovf_q;
    unf_d  = unf_q;
    if (en_i) begin
      unique case (sp_op_e'(op_i))
        SP_PUSH: begin
          addr_d = sp_q;
          if (sp_q == SP_LIMIT) ovf_d = 1'b1;
          else                  sp_d  = sp_q - 1'b1;
        end
        SP_POP: begin
          // A refused pop reports the current SP rather than SP+1.
          if (sp_q == SP_TOP) begin
            addr_d = sp_q;
            unf_d  = 1'b1;
          end else begin
            addr_d = sp_q + 1'b1;
            sp_d   = sp_q + 1'b1;
          end
        end
        SP_LOAD: begin
          sp_d   = load_i;
          addr_d = load_i;
        end
        default: addr_d = sp_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sp_q   <= SP_TOP;
      addr_q <= SP_TOP;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      sp_q   <= sp_d;
      addr_q <= addr_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
    end
  end

  assign sp_o   = sp_q;
  assign addr_o = addr_q;
  assign ovf_o  = ovf_q;
  assign unf_o  = unf_q;

endmodule

// File: rtl/regfile_sp_bank.sv
// Decode-stage register file with bypass/forward muxing, stall-aware output register and
// stack pointer. Define REGFILE_R0_ZERO_EN to hardwire entry 0 to zero.
module regfile_sp_bank
  import regfile_pkg::*;
#(
  parameter int unsigned     DATA_W   = DEF_DATA_W,
  parameter int unsigned     ADDR_W   = DEF_ADDR_W,
  parameter int unsigned     SP_W     = DEF_SP_W,
  parameter logic [SP_W-1:0] SP_TOP   = 8'hFF,
  parameter logic [SP_W-1:0] SP_LIMIT = 8'h00
) (
  input logic              clk,
  input logic              reset,
  regfile_sp_bank_if.slave bus
);

  localparam int unsigned NUM_REGS = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] data1_q, data1_d;
  logic [DATA_W-1:0] data2_q, data2_d;
  logic              wr_ok;

`ifdef REGFILE_R0_ZERO_EN
  assign wr_ok = bus.wr_en && (bus.wr_addr != '0);
`else
  assign wr_ok = bus.wr_en;
`endif

  // Writeback ignores en_pipeline so a stalled pipe never drops a retiring result.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (wr_ok) begin
      regs_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  always_comb begin
    data1_d = regs_q[bus.rd_addr1];
    data2_d = regs_q[bus.rd_addr2];
    if (wr_ok && bus.wr_addr == bus.rd_addr1) data1_d = bus.wr_data;
    if (wr_ok && bus.wr_addr == bus.rd_addr2) data2_d = bus.wr_data;
    if (bus.fwd_sel == FWD_D1 || bus.fwd_sel == FWD_BOTH) data1_d = bus.fwd_data;
    if (bus.fwd_sel == FWD_D2 || bus.fwd_sel == FWD_BOTH) data2_d = bus.fwd_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data1_q <= '0;
      data2_q <= '0;
    end else if (bus.en_pipeline) begin
      data1_q <= data1_d;
      data2_q <= data2_d;
    end
  end

  assign bus.data1_out = data1_q;
  assign bus.data2_out = data2_q;

  stack_ptr_unit #(
    .SP_W     (SP_W),
    .SP_TOP   (SP_TOP),
    .SP_LIMIT (SP_LIMIT)
  ) u_sp (
    .clk    (clk),
    .reset  (reset),
    .en_i   (bus.en_pipeline),
    .op_i   (bus.sp_op),
    .load_i (bus.sp_load_data),
    .sp_o   (bus.sp_out),
    .addr_o (bus.sp_addr_out),
    .ovf_o  (bus.stack_overflow),
    .unf_o  (bus.stack_underflow)
  );

endmodule

// File: tb/tb_regfile_sp_bank.sv
// Directed self-checking bench for regfile_sp_bank (register file, bypass, forwarding,
// stall, stack pointer bounds, reset).
module tb_regfile_sp_bank;
  import regfile_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  regfile_sp_bank_if #(.DATA_W(32), .ADDR_W(5), .SP_W(8)) bus ();

  regfile_sp_bank #(
    .DATA_W   (32),
    .ADDR_W   (5),
    .SP_W     (8),
    .SP_TOP   (8'hFF),
    .SP_LIMIT (8'h00)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.en_pipeline  = 1'b1;
    bus.wr_en        = 1'b0;
    bus.wr_addr      = '0;
    bus.wr_data      = '0;
    bus.sp_op        = SP_HOLD;
    bus.sp_load_data = '0;
    bus.fwd_sel      = FWD_NONE;
    bus.fwd_data     = '0;
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
    step();
    bus.wr_en = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    bus.rd_addr1 = '0; bus.rd_addr2 = '0;
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    checks++;
    if (bus.data1_out !== 32'd0 || bus.data2_out !== 32'd0) begin
      errors++; $display("FAIL reset_data: got %h/%h want 0/0", bus.data1_out, bus.data2_out);
    end
    checks++;
    if (bus.sp_out !== 8'hFF || bus.sp_addr_out !== 8'hFF) begin
      errors++; $display("FAIL reset_sp: got sp=%h addr=%h want FF/FF", bus.sp_out, bus.sp_addr_out);
    end
    checks++;
    if (bus.stack_overflow !== 1'b0 || bus.stack_underflow !== 1'b0) begin
      errors++; $display("FAIL reset_flags: got ovf=%b unf=%b want 0/0",
                         bus.stack_overflow, bus.stack_underflow);
    end
  endtask

  task automatic test_readwrite();
    logic [31:0] exp0;
`ifdef REGFILE_R0_ZERO_EN
    exp0 = 32'd0;
`else
    exp0 = 32'd2;
`endif
    idle();
    write_reg(5'd0, 32'd2);
    write_reg(5'd5, 32'd7);
    write_reg(5'd2, 32'd18);
    write_reg(5'd3, 32'd9);
    bus.rd_addr1 = 5'd2; bus.rd_addr2 = 5'd0;
    step();
    checks++;
    if (bus.data1_out !== 32'd18 || bus.data2_out !== exp0) begin
      errors++; $display("FAIL read_2_0: got %0d/%0d want 18/%0d", bus.data1_out, bus.data2_out, exp0);
    end
    bus.rd_addr1 = 5'd5; bus.rd_addr2 = 5'd3;
    step();
    checks++;
    if (bus.data1_out !== 32'd7 || bus.data2_out !== 32'd9) begin
      errors++; $display("FAIL read_5_3: got %0d/%0d want 7/9", bus.data1_out, bus.data2_out);
    end
  endtask

  task automatic test_bypass_forward();
    idle();
    bus.rd_addr1 = 5'd4; bus.rd_addr2 = 5'd5;
    bus.wr_en = 1'b1; bus.wr_addr = 5'd4; bus.wr_data = 32'h55;
    step();
    checks++;
    if (bus.data1_out !== 32'h55 || bus.data2_out !== 32'd7) begin
      errors++; $display("FAIL bypass: got %h/%h want 55/7", bus.data1_out, bus.data2_out);
    end
    bus.wr_data = 32'h66; bus.fwd_sel = FWD_D1; bus.fwd_data = 32'hAA;
    step();
    checks++;
    if (bus.data1_out !== 32'hAA || bus.data2_out !== 32'd7) begin
      errors++; $display("FAIL fwd_d1_over_bypass: got %h/%h want AA/7", bus.data1_out, bus.data2_out);
    end
    bus.wr_en = 1'b0; bus.fwd_sel = FWD_D2; bus.fwd_data = 32'hBB;
    step();
    checks++;
    if (bus.data1_out !== 32'h66 || bus.data2_out !== 32'hBB) begin
      errors++; $display("FAIL fwd_d2: got %h/%h want 66/BB", bus.data1_out, bus.data2_out);
    end
    bus.fwd_sel = FWD_BOTH; bus.fwd_data = 32'hCC;
    step();
    checks++;
    if (bus.data1_out !== 32'hCC || bus.data2_out !== 32'hCC) begin
      errors++; $display("FAIL fwd_both: got %h/%h want CC/CC", bus.data1_out, bus.data2_out);
    end
  endtask

  task automatic test_stall();
    idle();
    bus.rd_addr1 = 5'd5; bus.rd_addr2 = 5'd3;
    step();
    bus.en_pipeline = 1'b0;
    bus.rd_addr1 = 5'd2; bus.rd_addr2 = 5'd4;
    bus.sp_op = SP_PUSH;
    bus.wr_en = 1'b1; bus.wr_addr = 5'd6; bus.wr_data = 32'h11;
    for (int i = 0; i < 3; i++) begin
      step();
      bus.wr_en = 1'b0;
      checks++;
      if (bus.data1_out !== 32'd7 || bus.data2_out !== 32'd9 ||
          bus.sp_out !== 8'hFF || bus.sp_addr_out !== 8'hFF) begin
        errors++; $display("FAIL stall_hold[%0d]: got %0d/%0d sp=%h addr=%h want 7/9 FF/FF",
                           i, bus.data1_out, bus.data2_out, bus.sp_out, bus.sp_addr_out);
      end
    end
    idle();
    bus.rd_addr1 = 5'd6;
    step();
    checks++;
    if (bus.data1_out !== 32'h11) begin
      errors++; $display("FAIL stall_write: got %h want 11", bus.data1_out);
    end
  endtask

  task automatic test_stack();
    logic [7:0] exp_addr [6];
    logic [7:0] exp_sp   [6];
    exp_addr = '{8'hFF, 8'hFE, 8'hFD, 8'hFD, 8'hFE, 8'hFF};
    exp_sp   = '{8'hFE, 8'hFD, 8'hFC, 8'hFD, 8'hFE, 8'hFF};
    idle();
    reset = 1'b1; step(); reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.sp_op = (i < 3) ? SP_PUSH : SP_POP;
      step();
      checks++;
      if (bus.sp_addr_out !== exp_addr[i] || bus.sp_out !== exp_sp[i] || bus.stack_underflow !== 1'b0) begin
        errors++; $display("FAIL stack_seq[%0d]: got addr=%h sp=%h unf=%b want %h/%h/0",
                           i, bus.sp_addr_out, bus.sp_out, bus.stack_underflow, exp_addr[i], exp_sp[i]);
      end
    end
    bus.sp_op = SP_POP;
    step();
    checks++;
    if (bus.sp_out !== 8'hFF || bus.sp_addr_out !== 8'hFF || bus.stack_underflow !== 1'b1) begin
      errors++; $display("FAIL underflow: got sp=%h addr=%h unf=%b want FF/FF/1",
                         bus.sp_out, bus.sp_addr_out, bus.stack_underflow);
    end
    bus.sp_op = SP_PUSH;
    step();
    bus.sp_op = SP_HOLD;
    step();
    checks++;
    if (bus.stack_underflow !== 1'b1 || bus.sp_out !== 8'hFE || bus.sp_addr_out !== 8'hFE) begin
      errors++; $display("FAIL underflow_sticky: got unf=%b sp=%h addr=%h want 1/FE/FE",
                         bus.stack_underflow, bus.sp_out, bus.sp_addr_out);
    end
  endtask

  task automatic test_overflow();
    idle();
    bus.sp_op = SP_LOAD; bus.sp_load_data = 8'h01;
    step();
    checks++;
    if (bus.sp_out !== 8'h01 || bus.sp_addr_out !== 8'h01 || bus.stack_overflow !== 1'b0) begin
      errors++; $display("FAIL load: got sp=%h addr=%h ovf=%b want 01/01/0",
                         bus.sp_out, bus.sp_addr_out, bus.stack_overflow);
    end
    bus.sp_op = SP_PUSH;
    step();
    checks++;
    if (bus.sp_out !== 8'h00 || bus.sp_addr_out !== 8'h01 || bus.stack_overflow !== 1'b0) begin
      errors++; $display("FAIL push_to_limit: got sp=%h addr=%h ovf=%b want 00/01/0",
                         bus.sp_out, bus.sp_addr_out, bus.stack_overflow);
    end
    step();
    checks++;
    if (bus.sp_out !== 8'h00 || bus.sp_addr_out !== 8'h00 || bus.stack_overflow !== 1'b1) begin
      errors++; $display("FAIL overflow: got sp=%h addr=%h ovf=%b want 00/00/1",
                         bus.sp_out, bus.sp_addr_out, bus.stack_overflow);
    end
    bus.sp_op = SP_HOLD;
    step();
    checks++;
    if (bus.stack_overflow !== 1'b1 || bus.stack_underflow !== 1'b1 || bus.sp_out !== 8'h00) begin
      errors++; $display("FAIL flags_sticky: got ovf=%b unf=%b sp=%h want 1/1/00",
                         bus.stack_overflow, bus.stack_underflow, bus.sp_out);
    end
  endtask

  task automatic test_reset_midop();
    idle();
    write_reg(5'd7, 32'd9);
    bus.rd_addr1 = 5'd7; bus.rd_addr2 = 5'd7;
    step();
    checks++;
    if (bus.data1_out !== 32'd9) begin
      errors++; $display("FAIL pre_reset_r7: got %0d want 9", bus.data1_out);
    end
    reset = 1'b1;
    bus.wr_en = 1'b1; bus.wr_addr = 5'd7; bus.wr_data = 32'd9;
    bus.sp_op = SP_PUSH;
    step();
    reset = 1'b0;
    idle();
    checks++;
    if (bus.sp_out !== 8'hFF || bus.sp_addr_out !== 8'hFF ||
        bus.stack_overflow !== 1'b0 || bus.stack_underflow !== 1'b0 || bus.data1_out !== 32'd0) begin
      errors++; $display("FAIL reset_midop_state: got sp=%h addr=%h ovf=%b unf=%b d1=%0d want FF/FF/0/0/0",
                         bus.sp_out, bus.sp_addr_out, bus.stack_overflow, bus.stack_underflow, bus.data1_out);
    end
    step();
    checks++;
    if (bus.data1_out !== 32'd0 || bus.data2_out !== 32'd0) begin
      errors++; $display("FAIL reset_midop_r7: got %0d/%0d want 0/0", bus.data1_out, bus.data2_out);
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.rd_addr1 = '0;
    bus.rd_addr2 = '0;
    idle();
    test_reset();
    test_readwrite();
    test_bypass_forward();
    test_stall();
    test_stack();
    test_overflow();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
